ascon_serial_io: RTL and testbench

Parametrised pin-side serial front end for the Ascon AEAD core. It accepts key, nonce, associated data and text over a SW-bit ready/valid lane in a fixed order, then launches the core in encrypt or decrypt mode. It streams the result text and 128-bit tag back out over a SW-bit lane with backpressure, and reports the core latency in clock cycles. It replaces the per-field 1-bit serial inputs at the top of the Ascon datapath.

---
 rtl/ascon_io_pkg.sv | 29 ++
 rtl/ascon_piso.sv | 38 +++
 rtl/ascon_serial_io.sv | 154 +++++++++++++++
 tb/tb_ascon_serial_io.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_io_pkg.sv
// rtl/ascon_io_pkg.sv - shared types, widths and beat-count helpers for the Ascon serial front end
package ascon_io_pkg;

  // Transfer phases of the serial front end
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    UNLOAD = 3'd4
  } ioState_e;

  localparam int NONCE_W = 128;
  localparam int TAG_W   = 128;

  localparam int DEF_K = 128;
  localparam int DEF_L = 40;
  localparam int DEF_Y = 80;

  // Number of lane beats needed to move a field of the given width
  function automatic int beatCount(input int bits, input int laneW);
    return bits / laneW;
  endfunction

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ascon_piso.sv
// rtl/ascon_piso.sv - parallel-load shift-out register emitting MSB-first lane chunks
module ascon_piso #(
  parameter int W  = 208,
  parameter int SW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  loadData,
  input  logic          shift,
  output logic [SW-1:0] data,
  output logic          last
);

  localparam int NB = W / SW;
  localparam int CW = $clog2(NB + 1);

  logic [W-1:0]  shReg;
  logic [CW-1:0] beat;

  // Load the whole result at once, then drop one chunk per consumed beat; a stall simply holds
  always_ff @(posedge clk) begin
    if (!rst) begin
      shReg <= '0;
      beat  <= '0;
    end else if (load) begin
      shReg <= loadData;
      beat  <= '0;
    end else if (shift) begin
      shReg <= W'({shReg, {SW{1'b0}}});
      beat  <= beat + 1'b1;
    end
  end

  assign data = shReg[W-1 -: SW];
  assign last = (beat == CW'(NB - 1));

endmodule

// File: rtl/ascon_serial_io.sv
// rtl/ascon_serial_io.sv - serial load / launch / serial unload front end for the Ascon AEAD core
module ascon_serial_io
  import ascon_io_pkg::*;
#(
  parameter int K  = DEF_K,
  parameter int L  = DEF_L,
  parameter int Y  = DEF_Y,
  parameter int SW = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SW-1:0]      in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  output logic [K-1:0]       key,
  output logic [NONCE_W-1:0] nonce,
  output logic [L-1:0]       associated_data,
  output logic [Y-1:0]       text,
  output logic               core_mode,
  output logic               core_start,
  input  logic               core_done,
  input  logic [Y-1:0]       core_text,
  input  logic [TAG_W-1:0]   core_tag,
  output logic [SW-1:0]      out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [15:0]        cycles,
  output logic               busy
);

  localparam int N_IN    = beatCount(K + NONCE_W + L + Y, SW);
  localparam int N_OUT   = beatCount(Y + TAG_W, SW);
  localparam int CW      = $clog2(maxOf(N_IN, N_OUT) + 1);
  localparam int B_KEY   = K / SW;
  localparam int B_NONCE = B_KEY + NONCE_W / SW;
  localparam int B_AD    = B_NONCE + L / SW;

  generate
    if ((K % SW) != 0 || (L % SW) != 0 || (Y % SW) != 0 || (128 % SW) != 0) begin : gBadLane
      $error("ascon_serial_io: K, L, Y and 128 must all be multiples of SW");
    end
    if (N_IN < 2) begin : gBadBeats
      $error("ascon_serial_io: a transfer must span at least two input beats");
    end
  endgenerate

  ioState_e      state, nextState;
  logic [CW-1:0] beatCnt;
  logic          accept;
  logic          pisoLoad, pisoShift, pisoLast;
  logic [SW-1:0] pisoData;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state and handshake outputs
  always_comb begin
    nextState  = state;
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nextState = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && beatCnt == CW'(N_IN - 1)) nextState = START;
      end
      START: begin
        core_start = 1'b1;
        nextState  = WAIT;
      end
      WAIT: begin
        if (core_done) nextState = UNLOAD;
      end
      UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready && pisoLast) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign busy   = (state != IDLE);

  // Input loader: first beat clears the fields and latches the mode, later beats fill key, nonce, AD, text in order
  always_ff @(posedge clk) begin
    if (!rst) begin
      beatCnt         <= '0;
      key             <= '0;
      nonce           <= '0;
      associated_data <= '0;
      text            <= '0;
      core_mode       <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        beatCnt         <= CW'(1);
        core_mode       <= in_mode;
        key             <= K'(in_data);
        nonce           <= '0;
        associated_data <= '0;
        text            <= '0;
      end else begin
        beatCnt <= beatCnt + 1'b1;
        if (beatCnt < CW'(B_KEY))
          key <= K'({key, in_data});
        else if (beatCnt < CW'(B_NONCE))
          nonce <= NONCE_W'({nonce, in_data});
        else if (beatCnt < CW'(B_AD))
          associated_data <= L'({associated_data, in_data});
        else
          text <= Y'({text, in_data});
      end
    end
  end

  // Latency counter: cleared on launch, counts every waiting cycle including the done cycle, then holds
  always_ff @(posedge clk) begin
    if (!rst)
      cycles <= '0;
    else if (state == START)
      cycles <= '0;
    else if (state == WAIT && cycles != 16'hFFFF)
      cycles <= cycles + 16'd1;
  end

  assign pisoLoad  = (state == WAIT) && core_done;
  assign pisoShift = (state == UNLOAD) && out_ready;

  ascon_piso #(
    .W  (Y + TAG_W),
    .SW (SW)
  ) uPiso (
    .clk      (clk),
    .rst      (rst),
    .load     (pisoLoad),
    .loadData ({core_text, core_tag}),
    .shift    (pisoShift),
    .data     (pisoData),
    .last     (pisoLast)
  );

  assign out_data = out_valid ? pisoData : '0;
  assign out_last = out_valid & pisoLast;

endmodule

// File: tb/tb_ascon_serial_io.sv
// tb/tb_ascon_serial_io.sv - directed self-checking bench for ascon_serial_io at SW=1 and SW=8
module tb_ascon_serial_io;

  localparam logic [127:0] KEY   = 128'h2db083053e848cefa30007336c47a5a1;
  localparam logic [127:0] NONCE = 128'h3f3607dbce3503ba84f5843d623de056;
  localparam logic [39:0]  AD    = 40'h4153434f4e;
  localparam logic [79:0]  TEXT  = 80'h87a59a2ea49b233259e3;
  localparam logic [79:0]  CTEXT = 80'hdeadbeef0123456789ab;
  localparam logic [127:0] CTAG  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, inValid, inMode, coreDone, outReady;
  logic [7:0]  inData;
  logic [79:0] coreText;
  logic [127:0] coreTag;

  logic         inReady1, mode1, start1, outValid1, outLast1, busy1;
  logic [127:0] key1, nonce1;
  logic [39:0]  ad1;
  logic [79:0]  text1;
  logic [0:0]   outData1;
  logic [15:0]  cycles1;

  logic         inReady8, mode8, start8, outValid8, outLast8, busy8;
  logic [127:0] key8, nonce8;
  logic [39:0]  ad8;
  logic [79:0]  text8;
  logic [7:0]   outData8;
  logic [15:0]  cycles8;

  ascon_serial_io #(.K(128), .L(40), .Y(80), .SW(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(inData[0:0]), .in_valid(inValid & ~sel), .in_ready(inReady1),
    .in_mode(inMode), .key(key1), .nonce(nonce1), .associated_data(ad1), .text(text1),
    .core_mode(mode1), .core_start(start1), .core_done(coreDone & ~sel), .core_text(coreText),
    .core_tag(coreTag), .out_data(outData1), .out_valid(outValid1), .out_ready(outReady & ~sel),
    .out_last(outLast1), .cycles(cycles1), .busy(busy1)
  );

  ascon_serial_io #(.K(128), .L(40), .Y(80), .SW(8)) dut8 (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid & sel), .in_ready(inReady8),
    .in_mode(inMode), .key(key8), .nonce(nonce8), .associated_data(ad8), .text(text8),
    .core_mode(mode8), .core_start(start8), .core_done(coreDone & sel), .core_text(coreText),
    .core_tag(coreTag), .out_data(outData8), .out_valid(outValid8), .out_ready(outReady & sel),
    .out_last(outLast8), .cycles(cycles8), .busy(busy8)
  );

  // Views of whichever instance is currently selected
  logic         inReady, coreMode, coreStart, outValid, outLast, busy;
  logic [127:0] key, nonce;
  logic [39:0]  ad;
  logic [79:0]  text;
  logic [7:0]   outData;
  logic [15:0]  cycles;

  assign inReady   = sel ? inReady8  : inReady1;
  assign coreMode  = sel ? mode8     : mode1;
  assign coreStart = sel ? start8    : start1;
  assign outValid  = sel ? outValid8 : outValid1;
  assign outLast   = sel ? outLast8  : outLast1;
  assign busy      = sel ? busy8     : busy1;
  assign key       = sel ? key8      : key1;
  assign nonce     = sel ? nonce8    : nonce1;
  assign ad        = sel ? ad8       : ad1;
  assign text      = sel ? text8     : text1;
  assign outData   = sel ? outData8  : {7'b0, outData1};
  assign cycles    = sel ? cycles8   : cycles1;

  int nCompared = 0;
  int nMismatched = 0;
  int starts1 = 0;
  int starts8 = 0;
  int loadCycles, unloadCycles, unloadBeats;
  logic [375:0] inVec;
  logic [207:0] expOut, outVec;

  // Count launch pulses seen by each instance
  always @(posedge clk) begin
    if (start1) starts1 <= starts1 + 1;
    if (start8) starts8 <= starts8 + 1;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_in_ready"}, 256'(inReady), 256'(1));
    check({tag, "_zero"}, 256'(|{key, nonce, ad, text, coreMode, coreStart, outData, outValid,
                                outLast, cycles, busy}), 256'(0));
  endtask

  task automatic checkFields(input string tag);
    check({tag, "_key"},   256'(key),   256'(KEY));
    check({tag, "_nonce"}, 256'(nonce), 256'(NONCE));
    check({tag, "_ad"},    256'(ad),    256'(AD));
    check({tag, "_text"},  256'(text),  256'(TEXT));
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_busy"},  256'(busy),     256'(0));
    check({tag, "_ready"}, 256'(inReady),  256'(1));
    check({tag, "_ovld"},  256'(outValid), 256'(0));
  endtask

  // Feed beats of inVec; in_mode is only correct on the first beat so later beats prove it is ignored
  task automatic loadVec(input int sw, input bit mode, input bit gaps, input bit stray, input int stopAt);
    int i, cyc;
    logic [375:0] tmp;
    bit acc;
    i = 0;
    cyc = 0;
    while (i < stopAt && cyc < 3000) begin
      tmp = inVec >> (376 - sw * (i + 1));
      inData = (sw == 8) ? tmp[7:0] : {7'b0, tmp[0]};
      inValid = !(gaps && (cyc % 3 == 2));
      inMode = (i == 0) ? mode : ~mode;
      coreDone = stray;
      acc = inValid && inReady;
      @(posedge clk); #1;
      cyc++;
      if (acc) i++;
    end
    inValid = 1'b0;
    coreDone = 1'b0;
    loadCycles = cyc;
    check("load_beats", 256'(i), 256'(stopAt));
  endtask

  // Called in the START cycle; raises core_done lat cycles after it
  task automatic runCore(input int lat);
    check("start_pulse", 256'(coreStart), 256'(1));
    @(posedge clk); #1;
    check("start_once", 256'(coreStart), 256'(0));
    repeat (lat - 1) begin
      @(posedge clk); #1;
    end
    coreDone = 1'b1;
    @(posedge clk); #1;
    coreDone = 1'b0;
    check("cycles", 256'(cycles), 256'((lat > 65535) ? 65535 : lat));
    check("out_valid_rise", 256'(outValid), 256'(1));
  endtask

  // Collect output beats, optionally with random stalls, checking hold-on-stall and the last flag
  task automatic unloadVec(input int sw, input bit rnd, input int stopAt);
    int n, cyc, nBeats;
    bit r, stalled, prevLast;
    logic [7:0] prevData;
    n = 0;
    cyc = 0;
    stalled = 0;
    prevData = '0;
    prevLast = 0;
    nBeats = 208 / sw;
    outVec = '0;
    while (n < stopAt && cyc < 3000) begin
      check("out_valid", 256'(outValid), 256'(1));
      if (stalled) begin
        check("stall_data", 256'(outData), 256'(prevData));
        check("stall_last", 256'(outLast), 256'(prevLast));
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      outReady = r;
      if (r) begin
        outVec = (outVec << sw) | 208'(outData);
        check("last_flag", 256'(outLast), 256'(n == nBeats - 1));
        n++;
        stalled = 0;
      end else begin
        stalled = 1;
        prevData = outData;
        prevLast = outLast;
      end
      @(posedge clk); #1;
      cyc++;
    end
    outReady = 1'b0;
    unloadCycles = cyc;
    unloadBeats = n;
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; inValid = 1'b0; inMode = 1'b0; coreDone = 1'b0; outReady = 1'b0;
    inData = '0; coreText = CTEXT; coreTag = CTAG;
    inVec = {KEY, NONCE, AD, TEXT};
    expOut = {CTEXT, CTAG};
    repeat (2) @(posedge clk);
    #1;
    checkReset("rst1");
    sel = 1'b1; #1;
    checkReset("rst8");
    sel = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // SW=1 encrypt: 376 beats, single launch right after the last beat
    loadVec(1, 1'b0, 1'b0, 1'b0, 376);
    check("sw1_load_cycles", 256'(loadCycles), 256'(376));
    checkFields("sw1");
    check("sw1_mode", 256'(coreMode), 256'(0));
    runCore(4);
    check("sw1_start_count", 256'(starts1), 256'(1));

    // Reset in the middle of a load abandons it
    rst = 1'b0; @(posedge clk); #1; rst = 1'b1; @(posedge clk); #1;
    loadVec(1, 1'b0, 1'b0, 1'b0, 100);
    rst = 1'b0; @(posedge clk); #1;
    checkReset("rst_load");
    rst = 1'b1; @(posedge clk); #1;

    // Fresh SW=1 transfer completes end to end
    loadVec(1, 1'b1, 1'b0, 1'b0, 376);
    checkFields("sw1b");
    check("sw1b_mode", 256'(coreMode), 256'(1));
    runCore(5);
    unloadVec(1, 1'b0, 208);
    check("sw1_out_beats", 256'(unloadBeats), 256'(208));
    check("sw1_out", 256'(outVec), 256'(expOut));
    checkIdle("sw1_idle");

    // SW=8: stray core_done in IDLE is ignored
    sel = 1'b1;
    coreDone = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkIdle("stray_idle");
    coreDone = 1'b0;

    // SW=8 decrypt, core_done also stray during LOAD
    loadVec(8, 1'b1, 1'b0, 1'b1, 47);
    check("sw8_load_cycles", 256'(loadCycles), 256'(47));
    checkFields("sw8");
    check("sw8_mode", 256'(coreMode), 256'(1));
    runCore(20);
    unloadVec(8, 1'b0, 26);
    check("sw8_out_cycles", 256'(unloadCycles), 256'(26));
    check("sw8_out", 256'(outVec), 256'(expOut));
    check("sw8_cycles_hold", 256'(cycles), 256'(20));
    checkIdle("b2b");

    // Back-to-back with input gaps and random output backpressure
    loadVec(8, 1'b1, 1'b1, 1'b0, 47);
    checkFields("gap");
    runCore(3);
    unloadVec(8, 1'b1, 26);
    check("bp_beats", 256'(unloadBeats), 256'(26));
    check("bp_out", 256'(outVec), 256'(expOut));
    checkIdle("bp_idle");

    // Reset while output beat 5 is presented
    loadVec(8, 1'b0, 1'b0, 1'b0, 47);
    runCore(2);
    unloadVec(8, 1'b0, 4);
    rst = 1'b0; @(posedge clk); #1;
    checkReset("rst_unload");
    rst = 1'b1; @(posedge clk); #1;

    // Fresh transfer with a very slow core saturates the latency count
    loadVec(8, 1'b0, 1'b0, 1'b0, 47);
    checkFields("sat");
    check("sat_mode", 256'(coreMode), 256'(0));
    runCore(70000);
    unloadVec(8, 1'b0, 26);
    check("sat_out", 256'(outVec), 256'(expOut));
    check("sat_cycles_hold", 256'(cycles), 256'(16'hFFFF));
    check("sw8_start_count", 256'(starts8), 256'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
